dct_2d: RTL and testbench

Two-dimensional 8×8 forward DCT-II engine for signed fixed-point image blocks. It takes one full 64-sample block per clock, applies a row-then-column separable integer DCT, and registers all 64 coefficients. It sits between the block-extraction logic, which tiles a 128×128 image into 8×8 windows, and the downstream coefficient consumer.

---
 rtl/dct_pkg.sv | 24 ++
 rtl/dct_2d_dct1d_8.sv | 37 +++
 rtl/dct_2d.sv | 71 +++++++
 tb/tb_dct_2d.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the 8x8 integer DCT: cosine table, rounding and
// the sample slice index used by the packed block buses.
package dct_pkg;

  localparam int RND   = 64;
  localparam int SHIFT = 7;

  // COS[u][x] = round(64*cos((2x+1)u*pi/16)), with the DC row scaled to 45
  localparam logic signed [7:0] COS [8][8] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
  };

  function automatic int idx(input int r, input int c);
    return 63 - (8 * r + c);
  endfunction

endpackage

// File: rtl/dct_2d_dct1d_8.sv
// 8-point 1-D integer DCT with half-up rounding; element 0 sits in the
// MSB slice of both the input and output vectors.
module dct1d_8
  import dct_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 19
) (
  input  logic [8*IN_W-1:0]  x,
  output logic [8*OUT_W-1:0] y
);

  // 8-bit coefficients plus an 8-term sum need 8+3 bits of growth
  localparam int ACC_W = IN_W + 11;

  logic signed [IN_W-1:0]  xs  [8];
  logic signed [ACC_W-1:0] acc [8];
  logic signed [OUT_W-1:0] ys  [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      xs[i] = x[(7-i)*IN_W +: IN_W];
    end
    for (int k = 0; k < 8; k++) begin
      acc[k] = ACC_W'(RND);
      for (int i = 0; i < 8; i++) begin
        acc[k] = acc[k] + ACC_W'(xs[i]) * ACC_W'(COS[k][i]);
      end
      ys[k] = OUT_W'(acc[k] >>> SHIFT);
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_out
    assign y[(7-k)*OUT_W +: OUT_W] = ys[k];
  end

endmodule

// File: rtl/dct_2d.sv
// 8x8 forward DCT: eight row transforms feed eight column transforms,
// then saturation and a single output register stage.
module dct_2d
  import dct_pkg::*;
#(
  parameter int N = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N*64-1:0] data_in,
  output logic            out_valid,
  output logic [N*64-1:0] data_out
);

  localparam int RW = N + 3;
  localparam int CW = RW + 4;

  localparam logic signed [CW-1:0] SAT_HI = {{(CW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_LO = {{(CW-N+1){1'b1}}, {(N-1){1'b0}}};

  function automatic logic signed [N-1:0] sat(input logic signed [CW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[N-1:0];
    else if (v < SAT_LO) return SAT_LO[N-1:0];
    else                 return v[N-1:0];
  endfunction

  logic [8*RW-1:0] row_p0 [8];
  logic [8*RW-1:0] colin_p0 [8];
  logic [8*CW-1:0] col_p0 [8];
  logic [N*64-1:0] ysat_p0;

  logic            vld_p1;
  logic [N*64-1:0] data_p1;

  for (genvar r = 0; r < 8; r++) begin : g_row
    dct1d_8 #(.IN_W(N), .OUT_W(RW)) u_row (
      .x (data_in[idx(r, 7)*N +: 8*N]),
      .y (row_p0[r])
    );
  end

  // transpose: column v gathers R[0..7][v], row 0 in the MSB slice
  for (genvar v = 0; v < 8; v++) begin : g_col
    for (genvar r = 0; r < 8; r++) begin : g_tr
      assign colin_p0[v][(7-r)*RW +: RW] = row_p0[r][(7-v)*RW +: RW];
    end
    dct1d_8 #(.IN_W(RW), .OUT_W(CW)) u_col (
      .x (colin_p0[v]),
      .y (col_p0[v])
    );
    for (genvar u = 0; u < 8; u++) begin : g_sat
      assign ysat_p0[idx(u, v)*N +: N] = sat(col_p0[v][(7-u)*CW +: CW]);
    end
  end

  // ---- stage p0 -> p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) data_p1 <= ysat_p0;
    end
  end

  assign out_valid = vld_p1;
  assign data_out  = data_p1;

endmodule

// File: tb/tb_dct_2d.sv
// Directed bench for dct_2d: uniform-block table, impulse placement,
// back-to-back streaming with hold, and asynchronous mid-stream reset.
module tb_dct_2d;

  localparam int N = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [N*64-1:0] data_in;
  logic            out_valid;
  logic [N*64-1:0] data_out;

  int errors = 0;
  int checks = 0;

  dct_2d #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic signed [15:0] fill;
    int               y00;
  } vec_t;

  vec_t tbl [8];

  function automatic int coef(input int u, input int v);
    logic signed [N-1:0] t;
    t = data_out[(63-(8*u+v))*N +: N];
    return int'(t);
  endfunction

  function automatic int nonzero_ac();
    int n = 0;
    for (int k = 1; k < 64; k++) begin
      if (coef(k / 8, k % 8) != 0) n++;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill_block(input logic signed [15:0] val);
    for (int k = 0; k < 64; k++) data_in[k*N +: N] = val;
  endtask

  initial begin
    // uniform blocks: hand-computed via two rounded passes of 360*x
    tbl[0] = '{"zeros",   16'sd0,      0};
    tbl[1] = '{"p100",    16'sd100,    790};
    tbl[2] = '{"m100",   -16'sd100,   -790};
    tbl[3] = '{"max",     16'sd32767,  32767};
    tbl[4] = '{"min",    -16'sd32768, -32768};
    tbl[5] = '{"p1",      16'sd1,      8};
    tbl[6] = '{"m1",     -16'sd1,     -8};
    tbl[7] = '{"p50",     16'sd50,     397};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_data_zero", int'(data_out != '0), 0);
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) begin
      fill_block(tbl[t].fill);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tbl[t].name, "_out_valid"}, int'(out_valid), 1);
      chk({tbl[t].name, "_y00"}, coef(0, 0), tbl[t].y00);
      chk({tbl[t].name, "_ac_nonzero"}, nonzero_ac(), 0);
    end

    // impulse at x[0][0]: Y[u][v] = floor((c_u(0)*c_v(0)+64)/128)
    data_in = '0;
    data_in[63*N +: N] = 16'sd128;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("imp_y00", coef(0, 0), 16);
    chk("imp_y01", coef(0, 1), 22);
    chk("imp_y10", coef(1, 0), 22);
    chk("imp_y11", coef(1, 1), 31);
    chk("imp_y77", coef(7, 7), 1);
    chk("imp_lsb_slice", coef(7, 6), 2);

    // three back-to-back blocks, then idle with hold
    fill_block(16'sd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("strm0_valid", int'(out_valid), 1);
    chk("strm0_y00", coef(0, 0), 8);
    fill_block(16'sd100);
    @(posedge clk); #1;
    chk("strm1_valid", int'(out_valid), 1);
    chk("strm1_y00", coef(0, 0), 790);
    fill_block(-16'sd100);
    @(posedge clk); #1;
    chk("strm2_valid", int'(out_valid), 1);
    chk("strm2_y00", coef(0, 0), -790);
    in_valid = 1'b0;
    fill_block(16'sd50);
    @(posedge clk); #1;
    chk("idle_valid", int'(out_valid), 0);
    chk("hold_y00", coef(0, 0), -790);
    @(posedge clk); #1;
    chk("hold2_y00", coef(0, 0), -790);
    chk("hold2_ac_nonzero", nonzero_ac(), 0);

    // asynchronous reset between edges during a valid stream
    fill_block(16'sd100);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_y00", coef(0, 0), 790);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data_zero", int'(data_out != '0), 0);
    @(posedge clk); #1;
    chk("inrst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_y00", coef(0, 0), 790);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
